cic_comb: RTL and testbench

Comb section of the CIC decimation filter; sits directly downstream of the decimator and consumes its held, rate-reduced integrator output.
- Implements N_STAGES cascaded differentiators y[n] = x[n] − x[n−DIFF_DELAY], evaluated once per decimated sample (in_valid strobe), fully pipelined.
- Produces the filter result with a valid strobe and a settled flag marking the end of the start-up transient.

---
 rtl/cic_pkg.sv | 19 +
 rtl/cic_comb_stage.sv | 43 ++++
 rtl/cic_comb.sv | 105 ++++++++++
 tb/tb_cic_comb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC decimation filter blocks.
//
// Contents:
//   MAX_STAGES      - largest supported stage count (integrator and comb alike)
//   MAX_DIFF_DELAY  - largest supported differential delay M
//   cic_bit_growth  - register growth N*clog2(R*M), used to size the datapath
package cic_pkg;

    localparam int unsigned MAX_STAGES     = 8;
    localparam int unsigned MAX_DIFF_DELAY = 2;

    // Bit growth of an N-stage CIC with decimation R and differential delay M.
    function automatic int unsigned cic_bit_growth(input int unsigned n,
                                                   input int unsigned r,
                                                   input int unsigned m);
        return n * $clog2(r * m);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb differentiator: y[n] = x[n] - x[n-DIFF_DELAY], evaluated on en.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active-high; clears delay line and output
//   en   - stage enable; delay line and output hold while low
//   x    - stage input sample, two's complement
//   y    - registered stage output, two's complement (modulo 2^WIDTH)
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DIFF_DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] dly_q [DIFF_DELAY];
    logic [WIDTH-1:0] y_q;

    // Subtraction wraps on purpose: integrator overflow cancels here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DIFF_DELAY); i++) begin
                dly_q[i] <= '0;
            end
            y_q <= '0;
        end else if (en) begin
            y_q      <= x - dly_q[DIFF_DELAY-1];
            dly_q[0] <= x;
            for (int i = 1; i < int'(DIFF_DELAY); i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign y = y_q;

endmodule

// File: rtl/cic_comb.sv
// Comb section of the CIC decimation filter. N_STAGES cascaded differentiators
// run once per decimated sample, fully pipelined (one stage per clock).
//
// Ports:
//   clk       - system clock (decimator fast clock)
//   rst       - asynchronous reset, active-high
//   in        - decimator output sample, two's complement
//   in_valid  - one-cycle strobe marking the cycle in is sampled
//   out       - comb result, two's complement
//   out_valid - one-cycle strobe, out is new; N_STAGES cycles after in_valid
//   settled   - high from the output of the N_STAGES*DIFF_DELAY-th sample on
module cic_comb
    import cic_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned N_STAGES   = 3,
    parameter int unsigned DIFF_DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             settled
);

    localparam int unsigned SETTLE_COUNT = N_STAGES * DIFF_DELAY;
    localparam int unsigned CNT_W        = $clog2(SETTLE_COUNT + 1);

    typedef logic [WIDTH-1:0] cic_sample_t;

    if (N_STAGES < 1 || N_STAGES > MAX_STAGES ||
        DIFF_DELAY < 1 || DIFF_DELAY > MAX_DIFF_DELAY) begin : g_param_check
        $fatal(1, "cic_comb: N_STAGES must be 1..8 and DIFF_DELAY 1 or 2");
    end

    // Valid pipeline: v[0] is the input strobe, v[k] enables stage k.
    logic [N_STAGES-1:0] v_q;
    logic [N_STAGES:0]   v;

    assign v = {v_q, in_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v[N_STAGES-1:0];
        end
    end

    cic_sample_t stage_x [N_STAGES];
    cic_sample_t stage_y [N_STAGES];

    for (genvar k = 0; k < int'(N_STAGES); k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_x[k] = in;
        end else begin : g_chain
            assign stage_x[k] = stage_y[k-1];
        end

        cic_comb_stage #(
            .WIDTH      (WIDTH),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (v[k]),
            .x   (stage_x[k]),
            .y   (stage_y[k])
        );
    end

    assign out       = stage_y[N_STAGES-1];
    assign out_valid = v[N_STAGES];

    // Saturating count of accepted strobes. The strobe that reaches the target
    // carries a mark down a pipeline parallel to v, so settled rises together
    // with that sample's out_valid rather than when it enters.
    logic [CNT_W-1:0]    cnt_q;
    logic [N_STAGES-1:0] mark_q;
    logic [N_STAGES:0]   mark;
    logic                settled_q;
    logic                mark_in;

    assign mark_in = in_valid && (cnt_q == CNT_W'(SETTLE_COUNT - 1));
    assign mark    = {mark_q, mark_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            mark_q    <= '0;
            settled_q <= 1'b0;
        end else begin
            if (in_valid && (cnt_q != CNT_W'(SETTLE_COUNT))) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            mark_q    <= mark[N_STAGES-1:0];
            settled_q <= settled_q | mark[N_STAGES];
        end
    end

    assign settled = settled_q | mark[N_STAGES];

endmodule

// File: tb/tb_cic_comb.sv
// Scoreboard bench for cic_comb: three instances cover (W16,N3,M1),
// (W16,N1,M2) and (W8,N1,M1). Stimulus pushes hand-computed expectations;
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_cic_comb;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] in_a = '0, out_a;
    logic        iv_a = 1'b0, ov_a, settled_a;
    logic [15:0] in_b = '0, out_b;
    logic        iv_b = 1'b0, ov_b, settled_b;
    logic [7:0]  in_c = '0, out_c;
    logic        iv_c = 1'b0, ov_c, settled_c;

    cic_comb #(.WIDTH(16), .N_STAGES(3), .DIFF_DELAY(1)) u_dut_a (
        .clk(clk), .rst(rst), .in(in_a), .in_valid(iv_a),
        .out(out_a), .out_valid(ov_a), .settled(settled_a)
    );
    cic_comb #(.WIDTH(16), .N_STAGES(1), .DIFF_DELAY(2)) u_dut_b (
        .clk(clk), .rst(rst), .in(in_b), .in_valid(iv_b),
        .out(out_b), .out_valid(ov_b), .settled(settled_b)
    );
    cic_comb #(.WIDTH(8), .N_STAGES(1), .DIFF_DELAY(1)) u_dut_c (
        .clk(clk), .rst(rst), .in(in_c), .in_valid(iv_c),
        .out(out_c), .out_valid(ov_c), .settled(settled_c)
    );

    typedef struct {
        logic [15:0] data;
        logic        stl;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int          errors = 0;
    int          checks = 0;
    int          n_in_a = 0;
    int          n_out_a = 0;
    logic [15:0] last_a = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_a = '0;
        end else begin
            if (ov_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_out_valid", 32'(ov_a), 32'd0);
                end else begin
                    e = q_a.pop_front();
                    check("a_out", 32'(out_a), 32'(e.data));
                    check("a_settled", 32'(settled_a), 32'(e.stl));
                    check("a_latency_cycle", cyc, e.cyc);
                    last_a = e.data;
                    n_out_a++;
                end
            end else begin
                check("a_out_hold", 32'(out_a), 32'(last_a));
            end
            if (ov_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_out_valid", 32'(ov_b), 32'd0);
                end else begin
                    e = q_b.pop_front();
                    check("b_out", 32'(out_b), 32'(e.data));
                    check("b_settled", 32'(settled_b), 32'(e.stl));
                    check("b_latency_cycle", cyc, e.cyc);
                end
            end
            if (ov_c) begin
                if (q_c.size() == 0) begin
                    check("c_unexpected_out_valid", 32'(ov_c), 32'd0);
                end else begin
                    e = q_c.pop_front();
                    check("c_out", 32'(out_c), 32'(e.data));
                    check("c_settled", 32'(settled_c), 32'(e.stl));
                    check("c_latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            iv_a = 1'b0;
            iv_b = 1'b0;
            iv_c = 1'b0;
        end
    endtask

    // Present one sample to instance d and record its expected output.
    task automatic strobe(input int d, input logic [15:0] val, input logic [15:0] e,
                          input logic es);
        exp_t x;
        @(posedge clk);
        #1;
        iv_a   = 1'b0;
        iv_b   = 1'b0;
        iv_c   = 1'b0;
        x.data = e;
        x.stl  = es;
        case (d)
            0: begin
                in_a  = val;
                iv_a  = 1'b1;
                x.cyc = cyc + 3;
                q_a.push_back(x);
                n_in_a++;
            end
            1: begin
                in_b  = val;
                iv_b  = 1'b1;
                x.cyc = cyc + 1;
                q_b.push_back(x);
            end
            default: begin
                in_c  = val[7:0];
                iv_c  = 1'b1;
                x.cyc = cyc + 1;
                q_c.push_back(x);
            end
        endcase
    endtask

    logic [15:0] imp_in  [5] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] imp_out [5] = '{16'h0001, 16'hFFFD, 16'h0003, 16'hFFFF, 16'h0000};

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(out_a), 32'd0);
        check("reset_out_valid", 32'(ov_a), 32'd0);
        check("reset_settled", 32'(settled_a), 32'd0);
        rst = 1'b0;
        idle(2);

        // Impulse, N=3 M=1, back-to-back strobes
        for (int i = 0; i < 5; i++) begin
            strobe(0, imp_in[i], imp_out[i], i >= 2);
        end
        idle(6);

        // Step, N=1 M=2
        strobe(1, 16'd5, 16'd5, 1'b0);
        strobe(1, 16'd5, 16'd5, 1'b1);
        strobe(1, 16'd5, 16'd0, 1'b1);
        strobe(1, 16'd5, 16'd0, 1'b1);
        idle(3);

        // Wrap-around, W=8
        strobe(2, 16'h007F, 16'h007F, 1'b1);
        strobe(2, 16'h0081, 16'h0002, 1'b1);
        idle(3);

        // Irregular strobe spacing, same impulse; already settled
        strobe(0, imp_in[0], imp_out[0], 1'b1);
        idle(3);
        strobe(0, imp_in[1], imp_out[1], 1'b1);
        idle(3);
        strobe(0, imp_in[2], imp_out[2], 1'b1);
        strobe(0, imp_in[3], imp_out[3], 1'b1);
        idle(17);
        strobe(0, imp_in[4], imp_out[4], 1'b1);
        idle(6);

        // Reset mid-stream: leave out at 100, then drop an in-flight sample
        strobe(0, 16'd100, 16'd100, 1'b1);
        idle(5);
        @(posedge clk);
        #1;
        in_a = 16'd100;
        iv_a = 1'b1;
        @(posedge clk);
        #1;
        iv_a = 1'b0;
        rst  = 1'b1;
        #1;
        check("async_reset_out", 32'(out_a), 32'd0);
        check("async_reset_out_valid", 32'(ov_a), 32'd0);
        check("async_reset_settled", 32'(settled_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        for (int i = 0; i < 5; i++) begin
            strobe(0, imp_in[i], imp_out[i], i >= 2);
        end
        idle(6);

        // Reset coincident with a strobe: sample dropped, next one sees zero history
        @(posedge clk);
        #1;
        rst  = 1'b1;
        in_a = 16'd55;
        iv_a = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        iv_a = 1'b0;
        strobe(0, 16'd9, 16'd9, 1'b0);
        idle(6);

        check("a_out_valid_count", n_out_a, n_in_a);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        check("c_queue_drained", q_c.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
